prog_seq_ctr: RTL and testbench

- Parametrised multi-program program counter for the single-cycle processor.
- Selects one of NPROG program entry points from successive Start pulses.
- Steps the PC through each program, applying relative and absolute branches, stall and halt.
- Drives instruction-ROM address, reports Running/Done to the testbench handshake, and flags exhausted programs and PC wrap.

---
 rtl/prog_seq_pkg.sv | 26 ++
 rtl/start_edge_det.sv | 24 ++
 rtl/prog_seq_ctr.sv | 129 ++++++++++++
 tb/tb_prog_seq_ctr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and default entry table for the multi-program sequencer.
// Entry addresses follow the instruction-ROM layout of the test programs.
package prog_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_t;

    localparam int DEF_L = 10;

    localparam logic [DEF_L-1:0] ENTRY_P0 = 10'd0;
    localparam logic [DEF_L-1:0] ENTRY_P1 = 10'd190;
    localparam logic [DEF_L-1:0] ENTRY_P2 = 10'd380;
    localparam logic [DEF_L-1:0] ENTRY_P3 = 10'd570;

    localparam logic [4*DEF_L-1:0] DEF_ENTRY = {
        ENTRY_P3,
        ENTRY_P2,
        ENTRY_P1,
        ENTRY_P0
    };

endpackage

// File: rtl/start_edge_det.sv
// Registers the testbench Start level and flags its rising/falling edges.
// A cleared start_r makes a Start held through reset look like a rise.
module start_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic rise,
    output logic fall
);

    logic start_r;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            start_r <= 1'b0;
        end else begin
            start_r <= Start;
        end
    end

    assign rise = Start & ~start_r;
    assign fall = ~Start & start_r;

endmodule

// File: rtl/prog_seq_ctr.sv
// Multi-program PC: launches entry points on Start pulses and steps the
// PC with halt, stall, absolute and relative (modulo 2^L) branches.
module prog_seq_ctr
    import prog_seq_pkg::*;
#(
    parameter int L     = 10,
    parameter int NPROG = 4,
    parameter int OFFW  = 8,
    parameter logic [NPROG*L-1:0] ENTRY = DEF_ENTRY,
    localparam int PW   = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          BranchAbs,
    input  logic          BranchUp,
    input  logic          BranchDown,
    input  logic [OFFW-1:0] PCTarget,
    input  logic [L-1:0]  AbsTarget,
    output logic [L-1:0]  ProgCtr,
    output logic [PW-1:0] ProgIdx,
    output logic          Running,
    output logic          Done,
    output logic          Exhausted,
    output logic          Wrap
);

    localparam int NW = $clog2(NPROG + 1);
    localparam logic [NW-1:0] NP = NW'(NPROG);

    state_t        state;
    logic [NW-1:0] next_prog;
    logic          rise;
    logic          fall;

    logic [L:0]    tgt_x;
    logic [L:0]    up_sum;
    logic [L:0]    dn_sum;
    logic [L-1:0]  inc_pc;
    logic [L-1:0]  entry_pc;

    start_edge_det u_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .rise  (rise),
        .fall  (fall)
    );

    // Bit L of the extended result is the carry/borrow that drives Wrap.
    assign tgt_x  = {{(L + 1 - OFFW){1'b0}}, PCTarget};
    assign up_sum = {1'b0, ProgCtr} - tgt_x;
    assign dn_sum = {1'b0, ProgCtr} + tgt_x;
    assign inc_pc = ProgCtr + L'(1);

    always_comb begin
        entry_pc = '0;
        for (int k = 0; k < NPROG; k++) begin
            if (next_prog == NW'(k)) begin
                entry_pc = ENTRY[k*L +: L];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            ProgCtr   <= '0;
            ProgIdx   <= '0;
            next_prog <= '0;
            Running   <= 1'b0;
            Done      <= 1'b0;
            Exhausted <= 1'b0;
            Wrap      <= 1'b0;
        end else begin
            Wrap <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (rise) begin
                        if (next_prog < NP) begin
                            state   <= ARMED;
                            Running <= 1'b0;
                            Done    <= 1'b0;
                        end else begin
                            Exhausted <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (fall) begin
                        ProgCtr   <= entry_pc;
                        ProgIdx   <= next_prog[PW-1:0];
                        next_prog <= next_prog + NW'(1);
                        state     <= RUN;
                        Running   <= 1'b1;
                        Done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state   <= DONE;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else if (!Stall) begin
                        if (BranchAbs) begin
                            ProgCtr <= AbsTarget;
                        end else if (BranchUp) begin
                            ProgCtr <= up_sum[L-1:0];
                            Wrap    <= up_sum[L];
                        end else if (BranchDown) begin
                            ProgCtr <= dn_sum[L-1:0];
                            Wrap    <= dn_sum[L];
                        end else begin
                            ProgCtr <= inc_pc;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_seq_ctr.sv
// Bench for prog_seq_ctr: directed scenarios then random stimulus,
// every cycle compared against an integer-arithmetic reference model.
module tb_prog_seq_ctr;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Halt = 1'b0;
    logic       Stall = 1'b0;
    logic       BranchAbs = 1'b0;
    logic       BranchUp = 1'b0;
    logic       BranchDown = 1'b0;
    logic [7:0] PCTarget = '0;
    logic [9:0] AbsTarget = '0;
    logic [9:0] ProgCtr;
    logic [1:0] ProgIdx;
    logic       Running;
    logic       Done;
    logic       Exhausted;
    logic       Wrap;

    int nchk = 0;
    int nerr = 0;

    int ent [4] = '{0, 190, 380, 570};
    int m_mode = 0;
    int m_pc = 0;
    int m_idx = 0;
    int m_next = 0;
    int m_exh = 0;
    int m_wrap = 0;
    int m_prev = 0;

    localparam int M_IDLE = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN = 2;
    localparam int M_DONE = 3;

    prog_seq_ctr dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .Stall      (Stall),
        .BranchAbs  (BranchAbs),
        .BranchUp   (BranchUp),
        .BranchDown (BranchDown),
        .PCTarget   (PCTarget),
        .AbsTarget  (AbsTarget),
        .ProgCtr    (ProgCtr),
        .ProgIdx    (ProgIdx),
        .Running    (Running),
        .Done       (Done),
        .Exhausted  (Exhausted),
        .Wrap       (Wrap)
    );

    always #5 Clk = ~Clk;

    task automatic check(string tag, int got, int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model();
        int s;
        int rise;
        int fall;
        if (Reset) begin
            m_mode = M_IDLE; m_pc = 0; m_idx = 0; m_next = 0;
            m_exh = 0; m_wrap = 0; m_prev = 0;
            return;
        end
        rise = (Start && !m_prev) ? 1 : 0;
        fall = (!Start && m_prev) ? 1 : 0;
        m_prev = Start ? 1 : 0;
        m_wrap = 0;
        if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (rise == 1) begin
                if (m_next < 4) m_mode = M_ARMED;
                else m_exh = 1;
            end
        end else if (m_mode == M_ARMED) begin
            if (fall == 1) begin
                m_pc = ent[m_next];
                m_idx = m_next;
                m_next++;
                m_mode = M_RUN;
            end
        end else begin
            if (Halt) begin
                m_mode = M_DONE;
            end else if (Stall) begin
                m_pc = m_pc;
            end else if (BranchAbs) begin
                m_pc = int'(AbsTarget);
            end else if (BranchUp) begin
                s = m_pc - int'(PCTarget);
                if (s < 0) begin m_wrap = 1; s += 1024; end
                m_pc = s;
            end else if (BranchDown) begin
                s = m_pc + int'(PCTarget);
                if (s >= 1024) begin m_wrap = 1; s -= 1024; end
                m_pc = s;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic check_all();
        check("pc", int'(ProgCtr), m_pc);
        check("idx", int'(ProgIdx), m_idx);
        check("running", int'(Running), (m_mode == M_RUN) ? 1 : 0);
        check("done", int'(Done), (m_mode == M_DONE) ? 1 : 0);
        check("exhausted", int'(Exhausted), m_exh);
        check("wrap", int'(Wrap), m_wrap);
    endtask

    task automatic step();
        @(posedge Clk);
        model();
        #1;
        check_all();
    endtask

    task automatic clr();
        Halt = 0; Stall = 0; BranchAbs = 0;
        BranchUp = 0; BranchDown = 0;
    endtask

    task automatic launch();
        Start = 1; step();
        Start = 0; step();
    endtask

    task automatic halt_prog();
        Halt = 1; step();
        Halt = 0;
    endtask

    initial begin
        Reset = 1; step();
        check("rst_pc", int'(ProgCtr), 0);
        Reset = 0;
        launch();
        check("p0_pc", int'(ProgCtr), 0);
        check("p0_run", int'(Running), 1);
        repeat (5) step();
        check("pc5", int'(ProgCtr), 5);
        Halt = 1; BranchDown = 1; PCTarget = 8'd3; step();
        clr();
        repeat (3) step();
        check("halt_hold", int'(ProgCtr), 5);
        launch();
        check("p1_pc", int'(ProgCtr), 190);
        check("p1_idx", int'(ProgIdx), 1);
        BranchUp = 1; PCTarget = 8'd200; step();
        check("up_wrap_pc", int'(ProgCtr), 1014);
        check("up_wrap", int'(Wrap), 1);
        BranchUp = 0; BranchDown = 1; PCTarget = 8'd20; step();
        check("dn_wrap_pc", int'(ProgCtr), 10);
        BranchUp = 1; PCTarget = 8'd4; step();
        check("updn_pc", int'(ProgCtr), 6);
        check("updn_wrap", int'(Wrap), 0);
        clr();
        BranchAbs = 1; AbsTarget = 10'd382; step();
        Stall = 1; AbsTarget = 10'd600;
        repeat (3) step();
        check("stall_pc", int'(ProgCtr), 382);
        Stall = 0; step();
        check("abs_pc", int'(ProgCtr), 600);
        clr();
        halt_prog();
        launch();
        check("p2_pc", int'(ProgCtr), 380);
        halt_prog();
        launch();
        check("p3_pc", int'(ProgCtr), 570);
        halt_prog();
        launch();
        check("exh", int'(Exhausted), 1);
        check("exh_pc", int'(ProgCtr), 570);
        Reset = 1; step();
        Reset = 0;
        launch();
        BranchAbs = 1; AbsTarget = 10'd383; step();
        clr();
        Start = 1; Reset = 1; step();
        check("mid_rst_pc", int'(ProgCtr), 0);
        Reset = 0; step();
        Start = 0; step();
        check("relaunch_run", int'(Running), 1);
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) Start = ~Start;
            Halt = ($urandom_range(0, 24) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            BranchAbs = ($urandom_range(0, 7) == 0);
            BranchUp = ($urandom_range(0, 4) == 0);
            BranchDown = ($urandom_range(0, 4) == 0);
            PCTarget = 8'($urandom);
            AbsTarget = 10'($urandom);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
